hazard_ctrl: RTL

Parametrised hazard unit for the 5-stage WISC pipeline, sitting between IF/ID and ID/EX.
- Detects load-use, flag→B/BR and register→BR hazards, then holds PC and IF/ID while injecting bubbles into ID/EX for a programmable number of cycles.
- Adds three things: a global freeze on memory-busy, an IF/ID flush on taken branches, and a saturating stall-cycle counter.
- A down-counter replaces the single-flop stall state, so load latency is a parameter.

---
 rtl/wisc_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_stall_timer.sv | 32 +++
 rtl/hazard_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC pipeline constants and small helpers used by the hazard unit.
package wisc_pkg;
    localparam int DEF_REG_W = 4;
    localparam int DEF_OPC_W = 4;

    localparam logic [3:0] OPC_B       = 4'b1100;
    localparam logic [3:0] OPC_BR      = 4'b1101;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_st_e;

    function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit: IF/ID, ID/EX, EX/MEM taps in, stall controls out.
interface hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [REG_W-1:0] idex_rd;
    logic [2:0]       idex_flag_en;
    logic             exmem_memread;
    logic [REG_W-1:0] exmem_rd;
    logic [OPC_W-1:0] ifid_opcode;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic [2:0]       ifid_cond;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ctrl_mux_en;
    logic             ifid_flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output idex_memread, idex_rd, idex_flag_en, exmem_memread, exmem_rd,
               ifid_opcode, ifid_rs, ifid_rt, ifid_cond, branch_taken, mem_busy,
        input  pc_write_en, ifid_write_en, ctrl_mux_en, ifid_flush, freeze, stall_cycles
    );

    modport slave (
        input  idex_memread, idex_rd, idex_flag_en, exmem_memread, exmem_rd,
               ifid_opcode, ifid_rs, ifid_rt, ifid_cond, branch_taken, mem_busy,
        output pc_write_en, ifid_write_en, ctrl_mux_en, ifid_flush, freeze, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_timer.sv
// Remaining-stall down-counter: loads max(rem, req), counts down, holds while frozen.
module hazard_stall_timer
    import wisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       hold,
    output logic [2:0] rem,
    output logic       busy
);
    logic [2:0] r_rem;
    logic [2:0] w_rem_nxt;
    logic [2:0] w_peak;
    stall_st_e  w_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rem <= 3'd0;
        else        r_rem <= w_rem_nxt;
    end

    // A new request extends to the longer of the two, it never accumulates.
    always_comb begin
        w_peak    = max3(r_rem, req);
        w_rem_nxt = r_rem;
        if (!hold) w_rem_nxt = (w_peak == 3'd0) ? 3'd0 : w_peak - 3'd1;
    end

    assign w_state = (r_rem != 3'd0) ? ST_STALL : ST_IDLE;
    assign busy    = (w_state == ST_STALL);
    assign rem     = r_rem;
endmodule

// File: rtl/hazard_ctrl.sv
// WISC hazard unit: load-use / flag / register-branch detection, bubble timing, freeze, flush.
module hazard_ctrl
    import wisc_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int OPC_W    = DEF_OPC_W,
    parameter int LU_STALL = 1,
    parameter int BR_STALL = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam logic [OPC_W-1:0] L_OPC_B  = OPC_W'(OPC_B);
    localparam logic [OPC_W-1:0] L_OPC_BR = OPC_W'(OPC_BR);
    localparam logic [2:0]       L_LU     = 3'(LU_STALL);
    localparam logic [2:0]       L_BR     = 3'(BR_STALL);

    logic             w_lu, w_fb, w_rb, w_is_b, w_is_br;
    logic [2:0]       w_req;
    logic [2:0]       w_rem;
    logic             w_busy;
    logic             w_stall;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (b == '0));
    endfunction

    assign w_is_b  = (hz.ifid_opcode == L_OPC_B);
    assign w_is_br = (hz.ifid_opcode == L_OPC_BR);

    assign w_lu = hz.idex_memread &
                  (match(hz.ifid_rs, hz.idex_rd) | match(hz.ifid_rt, hz.idex_rd));
    // Unconditional branches do not read flags, so only the flag term is masked.
    assign w_fb = (w_is_b | w_is_br) & (hz.idex_flag_en != 3'b000) &
                  (hz.ifid_cond != COND_UNCOND);
    // BR waits on any EX/MEM producer of rs, not just loads.
    assign w_rb = w_is_br & (match(hz.ifid_rs, hz.idex_rd) |
                  ((hz.exmem_memread | 1'b1) & match(hz.ifid_rs, hz.exmem_rd)));

    always_comb begin
        w_req = 3'd0;
        if (w_lu && (w_fb || w_rb)) w_req = max3(L_LU, L_BR);
        else if (w_lu)              w_req = L_LU;
        else if (w_fb || w_rb)      w_req = L_BR;
    end

    hazard_stall_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (w_req),
        .hold  (hz.mem_busy),
        .rem   (w_rem),
        .busy  (w_busy)
    );

    assign w_stall = (w_req != 3'd0) || (w_busy && (w_rem != 3'd0));

    assign hz.pc_write_en   = ~w_stall & ~hz.mem_busy;
    assign hz.ifid_write_en = ~w_stall & ~hz.mem_busy;
    assign hz.ctrl_mux_en   = ~w_stall;
    assign hz.freeze        = hz.mem_busy;
    assign hz.ifid_flush    = hz.branch_taken & ~w_stall & ~hz.mem_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        r_cnt <= '0;
        else if (w_stall && !hz.mem_busy && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
    end

    assign hz.stall_cycles = r_cnt;
endmodule
